// File: rtl/dp_ram_pkg.sv
// Shared types and constants for the parametrised dual-port RAM.
package dp_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Read-during-write behaviour on a same-address collision.
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/dp_ram_clear_ctrl.sv
// Clear engine: sweeps every word to zero after reset or on request.
//
// state | meaning
// CLEAR | writing 0 to mem[clr_ptr] each cycle; ports are locked out
// READY | normal operation; clr_req starts a new sweep
module dp_ram_clear_ctrl
  import dp_ram_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr_req,
  output logic              o_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_ptr;

  // Sweep pointer and state; the last word is written on the edge that returns to READY.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          if (r_clr_ptr == ADDR_W'(DEPTH - 1)) begin
            r_state   <= READY;
            r_clr_ptr <= '0;
          end else begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
          end
        end
        READY: begin
          if (i_clr_req) begin
            r_state   <= CLEAR;
            r_clr_ptr <= '0;
          end
        end
        default: begin
          r_state   <= CLEAR;
          r_clr_ptr <= '0;
        end
      endcase
    end
  end

  assign o_busy     = (r_state == CLEAR);
  assign o_clr_we   = (r_state == CLEAR);
  assign o_clr_addr = r_clr_ptr;

endmodule

// File: rtl/dp_ram_param.sv
// Parametrised single-clock dual-port RAM with built-in clear engine.
module dp_ram_param
  import dp_ram_pkg::*;
#(
  parameter int  RAM_WIDTH    = 8,
  parameter int  RAM_DEPTH    = 16,
  parameter int  READ_LATENCY = 1,
  parameter int  RDW_MODE     = RDW_OLD,
  localparam int ADDR_W       = $clog2(RAM_DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_enb,
  input  logic [ADDR_W-1:0]    i_wr_addr,
  input  logic [RAM_WIDTH-1:0] i_data_in,
  input  logic                 i_rd_enb,
  input  logic [ADDR_W-1:0]    i_rd_addr,
  output logic [RAM_WIDTH-1:0] o_data_out,
  output logic                 o_rd_valid,
  input  logic                 i_clr_req,
  output logic                 o_busy
);

  logic [RAM_WIDTH-1:0] r_mem [RAM_DEPTH];

  logic                 w_busy;
  logic                 w_clr_we;
  logic [ADDR_W-1:0]    w_clr_addr;
  logic                 w_wr_in_range;
  logic                 w_rd_in_range;
  logic                 w_wr_ok;
  logic                 w_rd_ok;
  logic [RAM_WIDTH-1:0] w_rd_data;
  logic                 r_s1_v;
  logic [RAM_WIDTH-1:0] r_s1_d;

  dp_ram_clear_ctrl #(
    .DEPTH  (RAM_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr_req  (i_clr_req),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  // Range checks only matter when the depth leaves unused address codes.
  if ((2 ** ADDR_W) == RAM_DEPTH) begin : g_pow2
    assign w_wr_in_range = 1'b1;
    assign w_rd_in_range = 1'b1;
  end else begin : g_npow2
    assign w_wr_in_range = (i_wr_addr < ADDR_W'(RAM_DEPTH));
    assign w_rd_in_range = (i_rd_addr < ADDR_W'(RAM_DEPTH));
  end

  // A clear request in the same cycle wins over a user write.
  assign w_wr_ok = !w_busy && i_wr_enb && !i_clr_req && w_wr_in_range;
  assign w_rd_ok = !w_busy && i_rd_enb;

  // Read word selection: out-of-range reads give zero; bypass only when the write really lands.
  always_comb begin
    w_rd_data = '0;
    if (w_rd_in_range) begin
      if ((RDW_MODE == RDW_NEW) && w_wr_ok && (i_wr_addr == i_rd_addr))
        w_rd_data = i_data_in;
      else
        w_rd_data = r_mem[i_rd_addr];
    end
  end

  // Array write port, shared between the clear sweep and user writes; no reset on storage.
  always_ff @(posedge i_clk) begin
    if (w_clr_we)
      r_mem[w_clr_addr] <= '0;
    else if (w_wr_ok)
      r_mem[i_wr_addr] <= i_data_in;
  end

  // First read stage: data register only loads on an accepted read so it holds otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_v <= 1'b0;
      r_s1_d <= '0;
    end else begin
      r_s1_v <= w_rd_ok;
      if (w_rd_ok)
        r_s1_d <= w_rd_data;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                 r_s2_v;
    logic [RAM_WIDTH-1:0] r_s2_d;

    // Extra output stage; keeps running during a clear so an in-flight read still completes.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_s2_v <= 1'b0;
        r_s2_d <= '0;
      end else begin
        r_s2_v <= r_s1_v;
        if (r_s1_v)
          r_s2_d <= r_s1_d;
      end
    end

    assign o_rd_valid = r_s2_v;
    assign o_data_out = r_s2_d;
  end else begin : g_lat1
    assign o_rd_valid = r_s1_v;
    assign o_data_out = r_s1_d;
  end

  assign o_busy = w_busy;

endmodule

// File: tb/tb_dp_ram_param.sv
// Bench for dp_ram_param: two instances (16x8/lat1/old-data and 12x8/lat2/new-data)
// share one stimulus stream; a behavioural model predicts each instance every cycle.
module tb_dp_ram_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_enb, rd_enb, clr_req;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] data_in;

  logic [7:0] a_dout, b_dout;
  logic       a_rv, b_rv, a_busy, b_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dp_ram_param u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_wr_enb(wr_enb), .i_wr_addr(wr_addr),
    .i_data_in(data_in), .i_rd_enb(rd_enb), .i_rd_addr(rd_addr),
    .o_data_out(a_dout), .o_rd_valid(a_rv), .i_clr_req(clr_req), .o_busy(a_busy)
  );

  dp_ram_param #(.RAM_DEPTH(12), .READ_LATENCY(2), .RDW_MODE(1)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_wr_enb(wr_enb), .i_wr_addr(wr_addr),
    .i_data_in(data_in), .i_rd_enb(rd_enb), .i_rd_addr(rd_addr),
    .o_data_out(b_dout), .o_rd_valid(b_rv), .i_clr_req(clr_req), .o_busy(b_busy)
  );

  function automatic int dep_of(int k); return (k == 0) ? 16 : 12; endfunction
  function automatic int lat_of(int k); return (k == 0) ? 1 : 2;   endfunction
  function automatic int rdw_of(int k); return (k == 0) ? 0 : 1;   endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model state: memory contents, remaining clear cycles, and results scheduled by due cycle.
  int  m_mem [2][16];
  int  m_busy [2];
  bit  m_v [2];
  int  m_d [2];
  bit  due_v [2][4];
  int  due_d [2][4];
  int  cyc = 0;

  always @(posedge clk or posedge rst) begin
    int  dep, val, slot;
    bit  wr_ok;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] = dep_of(k);
        m_v[k] = 1'b0;
        m_d[k] = 0;
        for (int s = 0; s < 4; s++) due_v[k][s] = 1'b0;
      end
    end else begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
        dep = dep_of(k);
        if (m_busy[k] > 0) begin
          m_mem[k][dep - m_busy[k]] = 0;
          m_busy[k]--;
        end else begin
          wr_ok = wr_enb && !clr_req && (int'(wr_addr) < dep);
          if (rd_enb) begin
            if (int'(rd_addr) >= dep) val = 0;
            else if (rdw_of(k) == 1 && wr_ok && wr_addr == rd_addr) val = int'(data_in);
            else val = m_mem[k][rd_addr];
            slot = (cyc + lat_of(k) - 1) % 4;
            due_v[k][slot] = 1'b1;
            due_d[k][slot] = val;
          end
          if (wr_ok) m_mem[k][wr_addr] = int'(data_in);
          if (clr_req) m_busy[k] = dep;
        end
        slot = cyc % 4;
        m_v[k] = due_v[k][slot];
        if (m_v[k]) m_d[k] = due_d[k][slot];
        due_v[k][slot] = 1'b0;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("a_busy",  {31'd0, a_busy}, {31'd0, m_busy[0] > 0});
    chk("a_valid", {31'd0, a_rv},   {31'd0, m_v[0]});
    chk("a_data",  {24'd0, a_dout}, m_d[0]);
    chk("b_busy",  {31'd0, b_busy}, {31'd0, m_busy[1] > 0});
    chk("b_valid", {31'd0, b_rv},   {31'd0, m_v[1]});
    chk("b_data",  {24'd0, b_dout}, m_d[1]);
  end

  task automatic step(bit we, int wa, int d, bit re, int ra, bit cr);
    logic [31:0] t_wa, t_d, t_ra;
    t_wa = wa; t_d = d; t_ra = ra;
    wr_enb  = we;
    wr_addr = t_wa[3:0];
    data_in = t_d[7:0];
    rd_enb  = re;
    rd_addr = t_ra[3:0];
    clr_req = cr;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic count_clear(string tag);
    int na, nb;
    na = 0; nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (a_busy) na++;
      if (b_busy) nb++;
      idle();
    end
    chk({tag, "_len_a"}, na, 16);
    chk({tag, "_len_b"}, nb, 12);
  endtask

  initial begin
    wr_enb = 0; rd_enb = 0; clr_req = 0;
    wr_addr = 0; rd_addr = 0; data_in = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Power-up clear length, then everything reads back zero.
    count_clear("pwrup_clr");
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 1, i, 0);
      if (i == 0) begin
        chk("t1_a_valid0", {31'd0, a_rv}, 1);
        chk("t1_a_data0", {24'd0, a_dout}, 0);
      end
    end
    idle(); idle();

    // Fill with 3*i+1 and read back-to-back.
    for (int i = 0; i < 16; i++) step(1, i, 3 * i + 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 1, i, 0);
      if (i == 5) chk("t2_a_addr5", {24'd0, a_dout}, 16);
    end
    chk("t2_a_last", {24'd0, a_dout}, 46);
    idle();
    chk("t2_b_oor_valid", {31'd0, b_rv}, 1);
    chk("t2_b_oor_data", {24'd0, b_dout}, 0);
    idle();

    // Same-address read during write.
    step(1, 5, 'h10, 0, 0, 0);
    step(1, 5, 'hA5, 1, 5, 0);
    chk("t3_a_old", {24'd0, a_dout}, 'h10);
    idle();
    chk("t3_b_new", {24'd0, b_dout}, 'hA5);
    step(0, 0, 0, 1, 5, 0);
    chk("t3_a_after", {24'd0, a_dout}, 'hA5);
    idle();
    chk("t3_b_after", {24'd0, b_dout}, 'hA5);

    // Clear request collides with a write; reads in the busy window are ignored.
    step(1, 3, 'h77, 1, 3, 1);
    chk("t4_a_rd_in_clr", {24'd0, a_dout}, 10);
    chk("t4_a_busy", {31'd0, a_busy}, 1);
    for (int i = 0; i < 20; i++) step($urandom_range(0, 1), $urandom_range(0, 15),
                                     $urandom_range(0, 255), 1, $urandom_range(0, 15),
                                     $urandom_range(0, 1));
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 1, i, 0);
      if (i == 3) chk("t4_a_cleared3", {24'd0, a_dout}, 0);
    end
    idle(); idle();

    // Non-power-of-two depth: out-of-range write/read on the 12-deep instance.
    step(1, 13, 'h3C, 0, 0, 0);
    step(1, 11, 'h5A, 0, 0, 0);
    step(0, 0, 0, 1, 13, 0);
    idle();
    chk("t6_b_oor_valid", {31'd0, b_rv}, 1);
    chk("t6_b_oor_data", {24'd0, b_dout}, 0);
    step(0, 0, 0, 1, 11, 0);
    idle();
    chk("t6_b_addr11", {24'd0, b_dout}, 'h5A);

    // Reset while a latency-2 read is in flight.
    step(0, 0, 0, 1, 7, 0);
    idle_drive();
    #2 rst = 1'b1;
    #1;
    chk("t5_b_valid_rst", {31'd0, b_rv}, 0);
    chk("t5_b_data_rst", {24'd0, b_dout}, 0);
    chk("t5_a_data_rst", {24'd0, a_dout}, 0);
    chk("t5_b_busy_rst", {31'd0, b_busy}, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    count_clear("rst_clr");

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255),
           $urandom_range(0, 1), $urandom_range(0, 15), ($urandom_range(0, 59) == 0));
    end
    repeat (20) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Drop all strobes without consuming a clock so reset lands before the next edge.
  task automatic idle_drive();
    wr_enb = 0; rd_enb = 0; clr_req = 0;
  endtask

endmodule
